irq_sched_148: RTL

IRQ_SCHED_148 -- requirements
Module: irq_sched_148

---
 rtl/irq_sched_148.sv | 130 +++++++++++++
 1 files changed

// File: rtl/irq_sched_148.sv
// irq_sched_148: 8-input edge-triggered interrupt scheduler.
// Falling edges on irq_n latch into a pending register. The highest unmasked
// pending request is granted and held until acknowledged. A one-cycle HOLD
// follows every acknowledge. eo_n lets a lower-priority stage grant when this
// stage has nothing eligible.
module irq_sched_148 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_n,
    input  logic       ei_n,
    input  logic [7:0] mask_in,
    input  logic       mask_wr,
    input  logic       ack,
    input  logic       ovf_clr,
    output logic       irq_valid,
    output logic [2:0] vec,
    output logic       gs_n,
    output logic       eo_n,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] prev_n_q;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] mask_q;
    logic       ovf_q;
    logic       ovf_d;
    logic       valid_q;
    logic [2:0] vec_q;

    logic [7:0] fall;
    logic [7:0] cand;
    logic [7:0] clr;
    logic       cand_any;
    logic       ovf_set;
    logic [2:0] sel;

    // A request line is new when it was high last cycle and is low now.
    assign fall     = prev_n_q & ~irq_n;
    assign cand     = pending_q & ~mask_q;
    assign cand_any = |cand;

    // Acknowledge clears only the bit currently being granted.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_clr
            assign clr[gi] = (state_q == GRANT) && ack && (vec_q == 3'(gi));
        end
    endgenerate

    // A fresh edge wins over a clear of the same bit; it only overflows when
    // the bit was already pending and is not being retired this cycle.
    assign pending_d = (pending_q & ~clr) | fall;
    assign ovf_set   = |(fall & pending_q & ~clr);
    assign ovf_d     = ovf_set | (ovf_q & ~ovf_clr);

    // Priority encoder: the highest set candidate index wins.
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) begin
                sel = i[2:0];
            end
        end
    end

    // Edge history, pending set/clear, mask register and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_n_q  <= 8'hFF;
            pending_q <= 8'h00;
            mask_q    <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            prev_n_q  <= irq_n;
            pending_q <= pending_d;
            if (mask_wr) begin
                mask_q <= mask_in;
            end
            ovf_q     <= ovf_d;
        end
    end

    // Grant FSM with registered valid/vec; vec is frozen for the whole grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            vec_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ei_n && cand_any) begin
                        state_q <= GRANT;
                        valid_q <= 1'b1;
                        vec_q   <= sel;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        state_q <= HOLD;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Cascade: pass enable down only when idle with nothing eligible here.
    assign eo_n      = ~(~ei_n & ~cand_any & (state_q == IDLE));
    assign irq_valid = valid_q;
    assign vec       = vec_q;
    assign gs_n      = ~valid_q;
    assign ovf       = ovf_q;

endmodule
